// File: rtl/debug_halt_sequencer.sv
// Debug halt entry/exit sequencer between the debug module and the pipeline
// control unit. Drains the pipeline before reporting halted, and serialises
// debug PC writes, GPR writes and resume requests one per cycle.
// Optional feature macro: DEBUG_SINGLE_STEP_EN (adds step_req_i and a STEP state).
module debug_halt_sequencer #(
  parameter int unsigned XLEN          = 64,
  parameter int unsigned DRAIN_TIMEOUT = 64,
  parameter int unsigned CNT_W         = $clog2(DRAIN_TIMEOUT) + 1
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            halt_req_i,
  input  logic            resume_req_i,
  input  logic            change_pc_req_i,
  input  logic [XLEN-1:0] change_pc_addr_i,
  input  logic            reg_wr_req_i,
  input  logic [4:0]      reg_wr_addr_i,
  input  logic [XLEN-1:0] reg_wr_data_i,
  input  logic            pipe_empty_i,
  input  logic            exception_pending_i,
  input  logic            wb_commit_i,
`ifdef DEBUG_SINGLE_STEP_EN
  input  logic            step_req_i,
`endif
  output logic            debug_halt_o,
  output logic            debug_change_pc_o,
  output logic [XLEN-1:0] debug_pc_o,
  output logic            debug_wr_valid_o,
  output logic [4:0]      debug_wr_addr_o,
  output logic [XLEN-1:0] debug_wr_data_o,
  output logic            halted_o,
  output logic            ack_o,
  output logic            drain_timeout_o
);

  localparam logic [2:0] RUN    = 3'd0;
  localparam logic [2:0] DRAIN  = 3'd1;
  localparam logic [2:0] HALTED = 3'd2;
  localparam logic [2:0] CHG_PC = 3'd3;
  localparam logic [2:0] REG_WR = 3'd4;
  localparam logic [2:0] RESUME = 3'd5;
  localparam logic [2:0] STEP   = 3'd6;

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DRAIN_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_FLAG = CNT_W'(DRAIN_TIMEOUT - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             step_done_q, step_done_d;
  logic             debug_halt_q, debug_halt_d;
  logic             debug_change_pc_q, debug_change_pc_d;
  logic [XLEN-1:0]  debug_pc_q, debug_pc_d;
  logic             debug_wr_valid_q, debug_wr_valid_d;
  logic [4:0]       debug_wr_addr_q, debug_wr_addr_d;
  logic [XLEN-1:0]  debug_wr_data_q, debug_wr_data_d;
  logic             halted_q, halted_d;
  logic             ack_q, ack_d;
  logic             drain_timeout_q, drain_timeout_d;

  logic step_req;
`ifdef DEBUG_SINGLE_STEP_EN
  assign step_req = step_req_i;
`else
  // Commit strobe only matters while stepping.
  logic unused_wb_commit;
  assign unused_wb_commit = wb_commit_i;
  assign step_req         = 1'b0;
`endif

  // Next-state, counter, sticky flag and registered-output computation.
  always_comb begin
    state_d         = state_q;
    cnt_d           = '0;
    step_done_d     = 1'b0;
    drain_timeout_d = drain_timeout_q;
    debug_pc_d      = debug_pc_q;
    debug_wr_addr_d = debug_wr_addr_q;
    debug_wr_data_d = debug_wr_data_q;

    case (state_q)
      RUN: begin
        if (halt_req_i && !exception_pending_i) state_d = DRAIN;
      end
      DRAIN: begin
        if (!halt_req_i) begin
          state_d = RUN;
        end else if (pipe_empty_i && !exception_pending_i) begin
          state_d = HALTED;
        end
      end
      HALTED: begin
        if (change_pc_req_i) begin
          state_d    = CHG_PC;
          debug_pc_d = change_pc_addr_i;
        end else if (reg_wr_req_i) begin
          state_d         = REG_WR;
          debug_wr_addr_d = reg_wr_addr_i;
          debug_wr_data_d = reg_wr_data_i;
        end else if (step_req) begin
          state_d = STEP;
        end else if (resume_req_i && !halt_req_i) begin
          state_d = RESUME;
        end
      end
      CHG_PC:  state_d = HALTED;
      REG_WR:  state_d = HALTED;
      RESUME:  state_d = RUN;
      STEP: begin
        // Once one instruction retires, fetch is re-stalled while any flush settles.
        if ((wb_commit_i || step_done_q) && !exception_pending_i) begin
          state_d = DRAIN;
        end else begin
          step_done_d = step_done_q | wb_commit_i;
        end
      end
      default: state_d = RUN;
    endcase

    // Drain counter restarts on DRAIN entry and saturates at the timeout.
    if (state_q == DRAIN && state_d == DRAIN) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
      if (cnt_d == CNT_FLAG) drain_timeout_d = 1'b1;
    end

    if (state_d == RESUME) drain_timeout_d = 1'b0;

    debug_halt_d      = (state_d == DRAIN) || (state_d == HALTED) ||
                        (state_d == CHG_PC) || (state_d == REG_WR) ||
                        ((state_d == STEP) && step_done_d);
    halted_d          = (state_d == HALTED) || (state_d == CHG_PC) || (state_d == REG_WR);
    debug_change_pc_d = (state_d == CHG_PC);
    debug_wr_valid_d  = (state_d == REG_WR);
    ack_d             = ((state_q == DRAIN) && (state_d == HALTED)) ||
                        (state_d == CHG_PC) || (state_d == REG_WR) || (state_d == RESUME);
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q           <= RUN;
      cnt_q             <= '0;
      step_done_q       <= 1'b0;
      debug_halt_q      <= 1'b0;
      debug_change_pc_q <= 1'b0;
      debug_pc_q        <= '0;
      debug_wr_valid_q  <= 1'b0;
      debug_wr_addr_q   <= '0;
      debug_wr_data_q   <= '0;
      halted_q          <= 1'b0;
      ack_q             <= 1'b0;
      drain_timeout_q   <= 1'b0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      step_done_q       <= step_done_d;
      debug_halt_q      <= debug_halt_d;
      debug_change_pc_q <= debug_change_pc_d;
      debug_pc_q        <= debug_pc_d;
      debug_wr_valid_q  <= debug_wr_valid_d;
      debug_wr_addr_q   <= debug_wr_addr_d;
      debug_wr_data_q   <= debug_wr_data_d;
      halted_q          <= halted_d;
      ack_q             <= ack_d;
      drain_timeout_q   <= drain_timeout_d;
    end
  end

  assign debug_halt_o      = debug_halt_q;
  assign debug_change_pc_o = debug_change_pc_q;
  assign debug_pc_o        = debug_pc_q;
  assign debug_wr_valid_o  = debug_wr_valid_q;
  assign debug_wr_addr_o   = debug_wr_addr_q;
  assign debug_wr_data_o   = debug_wr_data_q;
  assign halted_o          = halted_q;
  assign ack_o             = ack_q;
  assign drain_timeout_o   = drain_timeout_q;

endmodule

// File: tb/tb_debug_halt_sequencer.sv
// Directed bench for debug_halt_sequencer (DRAIN_TIMEOUT=8).
module tb_debug_halt_sequencer;

  localparam int unsigned XLEN = 64;

  logic            clk_i = 1'b0;
  logic            rstn_i;
  logic            halt_req_i, resume_req_i, change_pc_req_i, reg_wr_req_i;
  logic [XLEN-1:0] change_pc_addr_i, reg_wr_data_i;
  logic [4:0]      reg_wr_addr_i;
  logic            pipe_empty_i, exception_pending_i, wb_commit_i;
`ifdef DEBUG_SINGLE_STEP_EN
  logic            step_req_i;
`endif
  logic            debug_halt_o, debug_change_pc_o, debug_wr_valid_o;
  logic [XLEN-1:0] debug_pc_o, debug_wr_data_o;
  logic [4:0]      debug_wr_addr_o;
  logic            halted_o, ack_o, drain_timeout_o;

  int checks = 0;
  int errors = 0;

  debug_halt_sequencer #(.XLEN(XLEN), .DRAIN_TIMEOUT(8)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .halt_req_i(halt_req_i), .resume_req_i(resume_req_i),
    .change_pc_req_i(change_pc_req_i), .change_pc_addr_i(change_pc_addr_i),
    .reg_wr_req_i(reg_wr_req_i), .reg_wr_addr_i(reg_wr_addr_i),
    .reg_wr_data_i(reg_wr_data_i), .pipe_empty_i(pipe_empty_i),
    .exception_pending_i(exception_pending_i), .wb_commit_i(wb_commit_i),
`ifdef DEBUG_SINGLE_STEP_EN
    .step_req_i(step_req_i),
`endif
    .debug_halt_o(debug_halt_o), .debug_change_pc_o(debug_change_pc_o),
    .debug_pc_o(debug_pc_o), .debug_wr_valid_o(debug_wr_valid_o),
    .debug_wr_addr_o(debug_wr_addr_o), .debug_wr_data_o(debug_wr_data_o),
    .halted_o(halted_o), .ack_o(ack_o), .drain_timeout_o(drain_timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk_i);
  endtask

  // Compact status check: {debug_halt, halted, ack, change_pc, wr_valid, timeout}.
  task automatic check_st(input string tag, input logic [5:0] exp);
    check(tag, 64'({debug_halt_o, halted_o, ack_o, debug_change_pc_o,
                    debug_wr_valid_o, drain_timeout_o}), 64'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rstn_i = 1'b0;
    halt_req_i = 0; resume_req_i = 0; change_pc_req_i = 0; reg_wr_req_i = 0;
    change_pc_addr_i = '0; reg_wr_addr_i = '0; reg_wr_data_i = '0;
    pipe_empty_i = 0; exception_pending_i = 0; wb_commit_i = 0;
`ifdef DEBUG_SINGLE_STEP_EN
    step_req_i = 0;
`endif
    step(); step();
    check_st("reset_status", 6'b000000);
    check("reset_pc", debug_pc_o, 64'h0);
    rstn_i = 1'b1;
    step();
    check_st("run_idle", 6'b000000);

    // Halt with an in-flight pipeline; pipe empties 5 cycles later.
    halt_req_i = 1;
    step();
    check_st("drain_entry", 6'b100000);
    for (int i = 0; i < 4; i++) begin
      step();
      check_st("drain_wait", 6'b100000);
    end
    pipe_empty_i = 1;
    step();
    check_st("halted_ack", 6'b111000);
    step();
    check_st("halted_noack", 6'b110000);

    // Change PC and register write requested together.
    change_pc_req_i = 1; change_pc_addr_i = 64'h8000_0100;
    reg_wr_req_i = 1; reg_wr_addr_i = 5'd5; reg_wr_data_i = 64'hDEAD_BEEF;
    step();
    check_st("chgpc_strobe", 6'b111100);
    check("chgpc_pc", debug_pc_o, 64'h8000_0100);
    change_pc_req_i = 0; change_pc_addr_i = 64'h1234;
    step();
    check_st("chgpc_back", 6'b110000);
    check("pc_hold", debug_pc_o, 64'h8000_0100);
    step();
    check_st("regwr_strobe", 6'b111010);
    check("regwr_addr", 64'(debug_wr_addr_o), 64'd5);
    check("regwr_data", debug_wr_data_o, 64'hDEAD_BEEF);
    reg_wr_req_i = 0; reg_wr_data_i = 64'h5555;
    step();
    check_st("regwr_back", 6'b110000);
    check("wr_data_hold", debug_wr_data_o, 64'hDEAD_BEEF);

    // Resume is held off while halt_req_i is high.
    resume_req_i = 1;
    step();
    check_st("resume_held1", 6'b110000);
    step();
    check_st("resume_held2", 6'b110000);
    halt_req_i = 0;
    step();
    check_st("resume_ack", 6'b001000);
    resume_req_i = 0;
    step();
    check_st("run_after_resume", 6'b000000);

    // Halt during an exception: DRAIN entry delayed 3 cycles.
    pipe_empty_i = 0; exception_pending_i = 1; halt_req_i = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_st("exc_hold_run", 6'b000000);
    end
    exception_pending_i = 0;
    step();
    check_st("exc_drain_entry", 6'b100000);

    // Drain timeout after 7 cycles in DRAIN; change_pc ignored meanwhile.
    change_pc_req_i = 1; change_pc_addr_i = 64'hCAFE;
    for (int i = 1; i <= 7; i++) begin
      step();
      check_st("timeout_walk", (i == 7) ? 6'b100001 : 6'b100000);
      if (i == 2) change_pc_req_i = 0;
    end
    check("pc_unchanged", debug_pc_o, 64'h8000_0100);
    for (int i = 0; i < 3; i++) begin
      step();
      check_st("timeout_sticky", 6'b100001);
    end
    pipe_empty_i = 1;
    step();
    check_st("timeout_halted", 6'b111001);
    halt_req_i = 0; resume_req_i = 1;
    step();
    check_st("timeout_cleared", 6'b001000);
    resume_req_i = 0;
    step();
    check_st("run_again", 6'b000000);

    // Halt request dropped in DRAIN returns to RUN without ack.
    pipe_empty_i = 0; halt_req_i = 1;
    step();
    check_st("drain2", 6'b100000);
    halt_req_i = 0;
    step();
    check_st("drain_abort", 6'b000000);

    // Asynchronous reset mid-DRAIN.
    halt_req_i = 1;
    step();
    check_st("drain3", 6'b100000);
    rstn_i = 0;
    #1;
    check_st("async_rst_status", 6'b000000);
    check("async_rst_pc", debug_pc_o, 64'h0);
    check("async_rst_data", debug_wr_data_o, 64'h0);
    halt_req_i = 0;
    step();
    rstn_i = 1;
    step();

`ifdef DEBUG_SINGLE_STEP_EN
    // Single step: run until one commit, then re-halt with one ack.
    halt_req_i = 1; pipe_empty_i = 1;
    step();
    step();
    check_st("step_halted", 6'b111000);
    step_req_i = 1; pipe_empty_i = 0;
    step();
    check_st("step_run", 6'b000000);
    step();
    check_st("step_run2", 6'b000000);
    wb_commit_i = 1;
    step();
    check_st("step_redrain", 6'b100000);
    wb_commit_i = 0; pipe_empty_i = 1;
    step();
    check_st("step_ack", 6'b111000);
    step_req_i = 0;
    step();
    check_st("step_done", 6'b110000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/debug_halt_sequencer.md
Name: debug_halt_sequencer

Overview:
- Sequences debug halt entry and exit for the scalar core; sits between the debug module and the pipeline control unit.
- Drives the control unit's debug_halt, debug_change_pc and debug_wr_valid inputs, and the redirect PC and register-write payloads.
- Guarantees the pipeline is drained before the halted state is reported.
- Serialises debug PC writes, debug GPR writes and resume requests so that only one is presented to the pipeline per cycle.

Parameters:
- XLEN, 64, data/PC width.
- DRAIN_TIMEOUT, 64, cycles allowed in DRAIN before drain_timeout_o is flagged; must be ≥2.
- CNT_W, $clog2(DRAIN_TIMEOUT)+1, drain counter width.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  reset, asynchronous, active-low.
- halt_req_i  in  1  level; debug module requests halt.
- resume_req_i  in  1  level; held until ack_o.
- change_pc_req_i  in  1  level; held until ack_o.
- change_pc_addr_i  in  XLEN  new PC.
- reg_wr_req_i  in  1  level; held until ack_o.
- reg_wr_addr_i  in  5  GPR index.
- reg_wr_data_i  in  XLEN  GPR data.
- pipe_empty_i  in  1  no valid instruction in ID/RR/EXE/WB.
- exception_pending_i  in  1  exception/redirect flush in progress.
- wb_commit_i  in  1  instruction retired at WB this cycle.
- debug_halt_o  out  1  to control unit; stalls fetch.
- debug_change_pc_o  out  1  to control unit; PC redirect strobe.
- debug_pc_o  out  XLEN  redirect target.
- debug_wr_valid_o  out  1  to control unit/regfile; GPR write strobe.
- debug_wr_addr_o  out  5  GPR write index.
- debug_wr_data_o  out  XLEN  GPR write data.
- halted_o  out  1  core is halted and drained.
- ack_o  out  1  one-cycle completion pulse.
- drain_timeout_o  out  1  sticky drain-timeout error flag.

Behaviour:
- Reset values: state=RUN; all outputs 0; counter=0.
- Output registering: all outputs are registered and change on the clock edge that enters the state.
- RUN:
  - debug_halt_o=0.
  - If halt_req_i=1 and exception_pending_i=0: go to DRAIN and clear the counter.
  - If halt_req_i=1 and exception_pending_i=1: stay in RUN until exception_pending_i=0.
- DRAIN:
  - debug_halt_o=1; counter increments and saturates at DRAIN_TIMEOUT.
  - If pipe_empty_i=1 and exception_pending_i=0: go to HALTED, with halted_o=1 and a single ack_o pulse.
  - When the counter reaches DRAIN_TIMEOUT-1: set drain_timeout_o (sticky) and remain in DRAIN.
  - If halt_req_i drops while in DRAIN: go back to RUN, no ack.
- HALTED:
  - debug_halt_o=1, halted_o=1.
  - Request priority: change_pc_req_i > reg_wr_req_i > resume_req_i.
  - Change PC: go to CHG_PC.
  - Register write: go to REG_WR, capturing addr/data.
  - Resume: go to RESUME, only if halt_req_i=0; a resume request with halt_req_i=1 is held off.
- CHG_PC: one cycle; debug_change_pc_o=1, debug_halt_o=1, debug_pc_o=captured address, ack_o=1; then back to HALTED.
- REG_WR: one cycle; debug_wr_valid_o=1, debug_halt_o=1, ack_o=1; then back to HALTED.
- RESUME: one cycle; debug_halt_o=0, halted_o=0, ack_o=1; clears drain_timeout_o; then to RUN.
- ack handshake: a requester must drop its request within 1 cycle after ack_o. The FSM does not re-accept the same request in the cycle ack_o is high; it returns to HALTED first.
- Requests outside HALTED: change_pc/reg_wr/resume requests arriving in RUN or DRAIN are ignored (not acked) until HALTED.
- Strobe exclusivity: debug_change_pc_o and debug_wr_valid_o are never high in the same cycle.
- Payload hold: debug_pc_o and debug_wr_* hold their last value when not strobed.

Optional Feature:
- Macro: DEBUG_SINGLE_STEP_EN.
- With the macro:
  - Adds port step_req_i (in, 1, level, held until ack_o), priority just above resume.
  - HALTED → STEP: debug_halt_o=0 until the first wb_commit_i=1.
  - In that commit cycle the FSM returns to DRAIN with debug_halt_o=1; reaching HALTED then gives the normal ack_o.
  - If exception_pending_i=1 during STEP: wait for it to clear before entering DRAIN.
- Without the macro: no step_req_i port, no STEP state; area and behaviour are otherwise identical.

Test Plan:
- Halt with an in-flight pipeline: halt_req_i=1, pipe_empty_i rises 5 cycles later → debug_halt_o=1 the next cycle; halted_o=1 and a single ack_o pulse the cycle after pipe_empty_i.
- Halt during an exception: halt_req_i=1 with exception_pending_i=1 for 3 cycles → DRAIN entry is delayed 3 cycles; debug_halt_o stays 0 meanwhile.
- Change PC and register write together: change_pc_req_i and reg_wr_req_i both held → PC strobe with debug_pc_o=0x8000_0100 first, then a GPR write to x5 of 0xDEAD_BEEF two cycles later; two ack_o pulses total.
- Drain timeout: DRAIN_TIMEOUT=8 with pipe_empty_i stuck at 0 → drain_timeout_o=1 after 7 cycles in DRAIN; stays set until RESUME.
- Resume: halt_req_i=0 and resume_req_i=1 in HALTED → one ack; debug_halt_o=0 and halted_o=0; RUN; asynchronous reset asserted mid-DRAIN returns all outputs to 0 immediately.
- (DEBUG_SINGLE_STEP_EN) Single step: step_req_i=1 → debug_halt_o drops until one wb_commit_i pulse, then re-halts with exactly one ack_o.
